// File: rtl/memory_arbiter_rr_tagged_if.sv
// rtl/memory_arbiter_rr_tagged_if.sv - request, memory and response bundle for the tagged round-robin read arbiter
interface memory_arbiter_rr_tagged_if #(
  parameter int N                 = 5,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int MEMORY_WIDTH      = 16,
  parameter int OUTSTANDING_DEPTH = 4
);
  localparam int CNT_WIDTH = $clog2(OUTSTANDING_DEPTH) + 1;

  logic [N-1:0]                   in_valid;
  logic [N*MEMORY_ADDR_WIDTH-1:0] in_addr;
  logic [N-1:0]                   in_ready;
  logic                           out_valid;
  logic [MEMORY_ADDR_WIDTH-1:0]   out_addr;
  logic                           out_ready;
  logic                           mem_rsp_valid;
  logic [MEMORY_WIDTH-1:0]        mem_rsp_data;
  logic [N-1:0]                   rsp_valid;
  logic [MEMORY_WIDTH-1:0]        rsp_data;
  logic [CNT_WIDTH-1:0]           outstanding;
  logic                           rsp_error;

  // master: requesters plus memory model; slave: the arbiter
  modport master (
    output in_valid, in_addr, out_ready, mem_rsp_valid, mem_rsp_data,
    input  in_ready, out_valid, out_addr, rsp_valid, rsp_data, outstanding, rsp_error
  );

  modport slave (
    input  in_valid, in_addr, out_ready, mem_rsp_valid, mem_rsp_data,
    output in_ready, out_valid, out_addr, rsp_valid, rsp_data, outstanding, rsp_error
  );
endinterface

// File: rtl/memory_arbiter_rr_tagged.sv
// rtl/memory_arbiter_rr_tagged.sv - round-robin read arbiter with in-order id FIFO routing responses back to requesters
module memory_arbiter_rr_tagged #(
  parameter int N                 = 5,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int MEMORY_WIDTH      = 16,
  parameter int OUTSTANDING_DEPTH = 4
) (
  input logic                        clk,
  input logic                        rst,
  memory_arbiter_rr_tagged_if.slave  bus
);
  localparam int ID_WIDTH  = (N > 2) ? $clog2(N) : 1;
  localparam int CNT_WIDTH = $clog2(OUTSTANDING_DEPTH) + 1;
  localparam int PTR_WIDTH = $clog2(OUTSTANDING_DEPTH);

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(OUTSTANDING_DEPTH);
  localparam logic [ID_WIDTH-1:0]  LAST_ID = ID_WIDTH'(N - 1);
  localparam logic [N-1:0]         ONE_N   = N'(1);

  logic [ID_WIDTH-1:0]  last_grant_q, last_grant_d;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [ID_WIDTH-1:0]  id_fifo_q [OUTSTANDING_DEPTH];

  logic [ID_WIDTH-1:0]  winner;
  logic [ID_WIDTH-1:0]  cand;
  logic                 found;
  logic [ID_WIDTH-1:0]  head_id;
  logic                 out_valid_w;
  logic                 handshake;
  logic                 pop;
  logic                 spurious;

  // Scan starts one past the last grant so the previous winner is considered last.
  always_comb begin
    winner = last_grant_q;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = ID_WIDTH'((int'(last_grant_q) + k) % N);
      if (!found && bus.in_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // A full FIFO blocks issue even if a response pops this cycle; the slot frees next cycle.
  assign out_valid_w = !rst && (|bus.in_valid) && (cnt_q < DEPTH_C);
  assign handshake   = out_valid_w && bus.out_ready;

  assign bus.out_valid = out_valid_w;
  assign bus.out_addr  = bus.in_addr[winner*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
  assign bus.in_ready  = handshake ? (ONE_N << winner) : '0;

  assign head_id  = id_fifo_q[rd_ptr_q];
  assign pop      = !rst && bus.mem_rsp_valid && (cnt_q != '0);
  assign spurious = bus.mem_rsp_valid && (cnt_q == '0);

  assign bus.rsp_valid   = pop ? (ONE_N << head_id) : '0;
  assign bus.rsp_data    = bus.mem_rsp_data;
  assign bus.outstanding = cnt_q;
  assign bus.rsp_error   = err_q;

  always_comb begin
    last_grant_d = handshake ? winner : last_grant_q;
    wr_ptr_d     = wr_ptr_q + PTR_WIDTH'(handshake);
    rd_ptr_d     = rd_ptr_q + PTR_WIDTH'(pop);
    err_d        = err_q | spurious;
    cnt_d        = cnt_q;
    case ({handshake, pop})
      2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
      2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= LAST_ID;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  // Id storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (handshake) begin
      id_fifo_q[wr_ptr_q] <= winner;
    end
  end
endmodule
